// File: rtl/avl_memcpy_pkg.sv
// Shared types and default widths for the Avalon-MM memcpy responder.
package avl_memcpy_pkg;

    localparam int ADDR_W_DEF     = 27;
    localparam int DATA_W_DEF     = 512;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RESP
    } t_memcpy_state;

    typedef logic [DATA_W_DEF-1:0] t_line;

endpackage

// File: rtl/memcpy_line_fifo.sv
// First-word-fall-through line buffer: the head entry is held in a register,
// so a line pushed in cycle N is presented on popData in cycle N+1.
module memcpy_line_fifo #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   SoftReset,
    input  logic                   push,
    input  logic [DATA_W-1:0]      pushData,
    input  logic                   pop,
    output logic [DATA_W-1:0]      popData,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wrPtrReg;
    logic [AW-1:0]     rdPtrReg;
    logic [AW-1:0]     rdPtrNext;
    logic [CW-1:0]     countReg;
    logic [CW-1:0]     keptCount;
    logic [DATA_W-1:0] headReg;

    always_comb begin
        rdPtrNext = rdPtrReg + AW'(pop);
        keptCount = countReg - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtrReg] <= pushData;
        end
    end

    // If anything survives this cycle's pop it is already in the array;
    // otherwise the head can only be the line arriving right now.
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
            headReg  <= '0;
        end else begin
            wrPtrReg <= wrPtrReg + AW'(push);
            rdPtrReg <= rdPtrNext;
            countReg <= keptCount + CW'(push);
            if (keptCount != '0) begin
                headReg <= mem[rdPtrNext];
            end else if (push) begin
                headReg <= pushData;
            end
        end
    end

    assign popData = headReg;
    assign count   = countReg;
    assign empty   = (countReg == '0);

endmodule

// File: rtl/avl_memcpy_srv.sv
// Memcpy responder: copies req_num lines from req_src to req_dst on one Avalon-MM bank.
// Optional AVL_MEMCPY_PERF_EN adds a perf_cycles counter of RUN cycles per copy.
module avl_memcpy_srv
    import avl_memcpy_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                SoftReset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [63:0]         req_src,
    input  logic [63:0]         req_dst,
    input  logic [63:0]         req_num,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [63:0]         resp_count,
    output logic                avl_read,
    output logic                avl_write,
    output logic [ADDR_W-1:0]   avl_address,
    output logic [DATA_W-1:0]   avl_writedata,
    output logic [DATA_W/8-1:0] avl_byteenable,
    output logic [6:0]          avl_burstcount,
    input  logic [DATA_W-1:0]   avl_readdata,
    input  logic                avl_readdatavalid,
    input  logic                avl_waitrequest
`ifdef AVL_MEMCPY_PERF_EN
    ,
    output logic [63:0]         perf_cycles
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    t_memcpy_state stateReg;
    logic [63:0]   srcReg;
    logic [63:0]   dstReg;
    logic [63:0]   numReg;
    logic [63:0]   rdIssuedReg;
    logic [63:0]   wrDoneReg;
    logic [CW-1:0] outstandingReg;

    logic [63:0]   rdIssuedNext;
    logic [63:0]   wrDoneNext;
    logic [CW-1:0] outstandingNext;
    logic [CW-1:0] fifoCountNext;
    logic [CW:0]   creditUsed;
    logic          reqAccept;
    logic          rdAccept;
    logic          wrAccept;
    logic          slotBusy;
    logic          rdEligible;
    logic          wrEligible;
    logic          wrPreferred;
    logic          copyDone;

    logic          fifoPush;
    logic          fifoPop;
    logic [CW-1:0] fifoCount;
    logic          fifoEmpty;

    memcpy_line_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .SoftReset (SoftReset),
        .push      (fifoPush),
        .pushData  (avl_readdata),
        .pop       (fifoPop),
        .popData   (avl_writedata),
        .count     (fifoCount),
        .empty     (fifoEmpty)
    );

    // Arbitration looks at the post-edge view so a command can be
    // re-issued in the same cycle the previous one is accepted.
    always_comb begin
        reqAccept       = (stateReg == ST_IDLE) && req_valid && req_ready;
        rdAccept        = avl_read && !avl_waitrequest;
        wrAccept        = avl_write && !avl_waitrequest;
        slotBusy        = (avl_read || avl_write) && avl_waitrequest;
        fifoPush        = (stateReg == ST_RUN) && avl_readdatavalid;
        fifoPop         = wrAccept && !fifoEmpty;
        rdIssuedNext    = rdIssuedReg + 64'(rdAccept);
        wrDoneNext      = wrDoneReg + 64'(fifoPop);
        outstandingNext = outstandingReg + CW'(rdAccept) - CW'(fifoPush);
        fifoCountNext   = fifoCount + CW'(fifoPush) - CW'(fifoPop);
        creditUsed      = {1'b0, outstandingNext} + {1'b0, fifoCountNext};
        rdEligible      = (rdIssuedNext < numReg) && (creditUsed < (CW + 1)'(FIFO_DEPTH));
        wrEligible      = (fifoCountNext != '0);
        wrPreferred     = (fifoCountNext >= CW'(FIFO_DEPTH / 2)) || !rdEligible;
        copyDone        = (wrDoneNext == numReg);
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            stateReg       <= ST_IDLE;
            req_ready      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_count     <= '0;
            avl_read       <= 1'b0;
            avl_write      <= 1'b0;
            avl_address    <= '0;
            srcReg         <= '0;
            dstReg         <= '0;
            numReg         <= '0;
            rdIssuedReg    <= '0;
            wrDoneReg      <= '0;
            outstandingReg <= '0;
        end else begin
            case (stateReg)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (reqAccept) begin
                        req_ready      <= 1'b0;
                        srcReg         <= req_src;
                        dstReg         <= req_dst;
                        numReg         <= req_num;
                        rdIssuedReg    <= '0;
                        wrDoneReg      <= '0;
                        outstandingReg <= '0;
                        if (req_num == '0) begin
                            stateReg   <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_count <= '0;
                        end else begin
                            stateReg    <= ST_RUN;
                            avl_read    <= 1'b1;
                            avl_address <= req_src[ADDR_W-1:0];
                        end
                    end
                end

                ST_RUN: begin
                    rdIssuedReg    <= rdIssuedNext;
                    wrDoneReg      <= wrDoneNext;
                    outstandingReg <= outstandingNext;
                    if (copyDone) begin
                        stateReg   <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_count <= wrDoneNext;
                        avl_read   <= 1'b0;
                        avl_write  <= 1'b0;
                    end else if (!slotBusy) begin
                        if (wrEligible && wrPreferred) begin
                            avl_read    <= 1'b0;
                            avl_write   <= 1'b1;
                            avl_address <= ADDR_W'(dstReg + wrDoneNext);
                        end else if (rdEligible) begin
                            avl_read    <= 1'b1;
                            avl_write   <= 1'b0;
                            avl_address <= ADDR_W'(srcReg + rdIssuedNext);
                        end else begin
                            avl_read  <= 1'b0;
                            avl_write <= 1'b0;
                        end
                    end
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        stateReg   <= ST_IDLE;
                    end
                end

                default: begin
                    stateReg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AVL_MEMCPY_PERF_EN
    always_ff @(posedge clk) begin
        if (SoftReset || reqAccept) begin
            perf_cycles <= '0;
        end else if (stateReg == ST_RUN) begin
            perf_cycles <= perf_cycles + 64'd1;
        end
    end
`endif

    assign avl_byteenable = '1;
    assign avl_burstcount = 7'd1;

endmodule

// File: tb/tb_avl_memcpy_srv.sv
// Scoreboard bench for avl_memcpy_srv: a behavioural Avalon memory answers reads,
// expected reads/writes are queued when each request is driven and checked on acceptance.
module tb_avl_memcpy_srv;
    import avl_memcpy_pkg::*;

    localparam int ADDR_W     = 27;
    localparam int DATA_W     = 512;
    localparam int FIFO_DEPTH = 8;

    logic                clk = 1'b0;
    logic                SoftReset;
    logic                req_valid;
    logic                req_ready;
    logic [63:0]         req_src;
    logic [63:0]         req_dst;
    logic [63:0]         req_num;
    logic                resp_valid;
    logic                resp_ready;
    logic [63:0]         resp_count;
    logic                avl_read;
    logic                avl_write;
    logic [ADDR_W-1:0]   avl_address;
    logic [DATA_W-1:0]   avl_writedata;
    logic [DATA_W/8-1:0] avl_byteenable;
    logic [6:0]          avl_burstcount;
    logic [DATA_W-1:0]   avl_readdata;
    logic                avl_readdatavalid;
    logic                avl_waitrequest;
`ifdef AVL_MEMCPY_PERF_EN
    logic [63:0]         perfCycles;
`endif

    avl_memcpy_srv #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk               (clk),
        .SoftReset         (SoftReset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_src           (req_src),
        .req_dst           (req_dst),
        .req_num           (req_num),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_count        (resp_count),
        .avl_read          (avl_read),
        .avl_write         (avl_write),
        .avl_address       (avl_address),
        .avl_writedata     (avl_writedata),
        .avl_byteenable    (avl_byteenable),
        .avl_burstcount    (avl_burstcount),
        .avl_readdata      (avl_readdata),
        .avl_readdatavalid (avl_readdatavalid),
        .avl_waitrequest   (avl_waitrequest)
`ifdef AVL_MEMCPY_PERF_EN
        ,
        .perf_cycles       (perfCycles)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        t_line             data;
    } t_wr_exp;

    typedef struct packed {
        int    due;
        t_line data;
    } t_rd_resp;

    t_wr_exp           expQ[$];
    logic [ADDR_W-1:0] rdQ[$];
    t_rd_resp          respQ[$];

    int  nCompared   = 0;
    int  nMismatched = 0;
    int  cyc         = 0;
    int  latency     = 3;
    bit  waitRandom  = 1'b0;
    int  stallErr    = 0;
    int  bothErr     = 0;
    int  cmdCount    = 0;
    int  wrCount     = 0;
    int  creditSum   = 0;
    int  maxCredit   = 0;
    time tAccept     = 0;

    task automatic checkVal(input string tag, input logic [511:0] got, input logic [511:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic t_line pat(input logic [ADDR_W-1:0] a);
        t_line d;
        for (int k = 0; k < 16; k++) begin
            d[k*32 +: 32] = {a, k[4:0]} ^ 32'h6D2B_79F5;
        end
        return d;
    endfunction

    // Behavioural memory: decides waitrequest for the coming edge, returns
    // read data L cycles after acceptance, and checks every accepted command.
    initial begin
        bit                prevStall;
        logic              prevRd;
        logic              prevWr;
        logic [ADDR_W-1:0] prevAddr;
        t_line             prevData;
        t_rd_resp          r;
        t_wr_exp           e;
        logic [ADDR_W-1:0] ra;
        prevStall         = 1'b0;
        prevRd            = 1'b0;
        prevWr            = 1'b0;
        prevAddr          = '0;
        prevData          = '0;
        avl_waitrequest   = 1'b0;
        avl_readdatavalid = 1'b0;
        avl_readdata      = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (prevStall && (avl_read !== prevRd || avl_write !== prevWr || avl_address !== prevAddr
                              || (avl_write && avl_writedata !== prevData))) begin
                stallErr++;
            end
            if (avl_read && avl_write) bothErr++;
            if (avl_read || avl_write) cmdCount++;
            avl_waitrequest = waitRandom ? ($urandom_range(0, 1) == 1) : 1'b0;
            prevStall = (avl_read || avl_write) && avl_waitrequest;
            prevRd    = avl_read;
            prevWr    = avl_write;
            prevAddr  = avl_address;
            prevData  = avl_writedata;

            avl_readdatavalid = 1'b0;
            if (respQ.size() > 0 && respQ[0].due <= cyc) begin
                r = respQ.pop_front();
                avl_readdatavalid = 1'b1;
                avl_readdata      = r.data;
            end
            if (avl_read && !avl_waitrequest) begin
                checkVal("rd_expected", 512'(rdQ.size() != 0), 512'(1));
                if (rdQ.size() != 0) begin
                    ra = rdQ.pop_front();
                    checkVal("rd_addr", 512'(avl_address), 512'(ra));
                end
                r.due  = cyc + latency;
                r.data = pat(avl_address);
                respQ.push_back(r);
                creditSum++;
            end
            if (avl_write && !avl_waitrequest) begin
                checkVal("wr_expected", 512'(expQ.size() != 0), 512'(1));
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkVal("wr_addr", 512'(avl_address), 512'(e.addr));
                    checkVal("wr_data", avl_writedata, e.data);
                end
                wrCount++;
                creditSum--;
            end
            if (creditSum > maxCredit) maxCredit = creditSum;
        end
    end

    task automatic sendReq(input logic [63:0] src, input logic [63:0] dst, input logic [63:0] num);
        t_wr_exp e;
        int      n;
        for (longint i = 0; i < longint'(num); i++) begin
            rdQ.push_back(ADDR_W'(src + 64'(i)));
            e.addr = ADDR_W'(dst + 64'(i));
            e.data = pat(ADDR_W'(src + 64'(i)));
            expQ.push_back(e);
        end
        $display("req  src=%0h dst=%0h num=%0d", src, dst, num);
        req_src   = src;
        req_dst   = dst;
        req_num   = num;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkVal("req_ready_seen", 512'(req_ready), 512'(1));
        @(posedge clk);
        tAccept = $time;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitResp(input logic [63:0] expCount, input int hold, output int lat);
        int n;
        n = 0;
        while (!resp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkVal("resp_valid_seen", 512'(resp_valid), 512'(1));
        lat = int'(($time - 5 - tAccept) / 10);
        $display("resp count=%0d cycles=%0d", resp_count, lat);
        checkVal("resp_count", 512'(resp_count), 512'(expCount));
        checkVal("writes_left", 512'(expQ.size()), 512'(0));
        checkVal("reads_left", 512'(rdQ.size()), 512'(0));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checkVal("hold_resp_valid", 512'(resp_valid), 512'(1));
            checkVal("hold_resp_count", 512'(resp_count), 512'(expCount));
            checkVal("hold_req_ready", 512'(req_ready), 512'(0));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkVal("resp_dropped", 512'(resp_valid), 512'(0));
        checkVal("req_ready_back", 512'(req_ready), 512'(1));
    endtask

    initial begin
        int lat;
        int c0;
        int n;
        int seen;
        SoftReset  = 1'b1;
        req_valid  = 1'b0;
        req_src    = '0;
        req_dst    = '0;
        req_num    = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("rst_req_ready", 512'(req_ready), 512'(0));
        checkVal("rst_resp_valid", 512'(resp_valid), 512'(0));
        checkVal("rst_resp_count", 512'(resp_count), 512'(0));
        checkVal("rst_avl_read", 512'(avl_read), 512'(0));
        checkVal("rst_avl_write", 512'(avl_write), 512'(0));
        checkVal("rst_avl_address", 512'(avl_address), 512'(0));
        checkVal("rst_avl_writedata", avl_writedata, 512'(0));
        SoftReset = 1'b0;
        @(negedge clk);
        checkVal("req_ready_after_rst", 512'(req_ready), 512'(1));

        // basic copy, zero-wait, latency 3
        latency = 3;
        sendReq(64'h100, 64'h200, 64'd4);
        checkVal("first_read_next_cycle", 512'(avl_read), 512'(1));
        checkVal("first_read_addr", 512'(avl_address), 512'(27'h100));
        waitResp(64'd4, 0, lat);
        checkVal("copy4_within_bound", 512'(lat <= 2 * 4 + 3 + 3), 512'(1));

        // zero-length copy
        c0 = cmdCount;
        sendReq(64'h40, 64'h80, 64'd0);
        checkVal("num0_resp_next_cycle", 512'(resp_valid), 512'(1));
        checkVal("num0_resp_count_early", 512'(resp_count), 512'(0));
        waitResp(64'd0, 0, lat);
        checkVal("num0_no_commands", 512'(cmdCount - c0), 512'(0));

        // random waitrequest, long latency
        latency    = 10;
        creditSum  = 0;
        maxCredit  = 0;
        stallErr   = 0;
        waitRandom = 1'b1;
        sendReq(64'h1000, 64'h3000, 64'd20);
        waitResp(64'd20, 0, lat);
        waitRandom = 1'b0;
        checkVal("credit_max_le_depth", 512'(maxCredit <= FIFO_DEPTH), 512'(1));
        checkVal("stable_while_stalled", 512'(stallErr), 512'(0));

        // address wrap at 2^27
        latency = 3;
        sendReq(64'h7FF_FFFE, 64'h500, 64'd4);
        waitResp(64'd4, 0, lat);

        // reset in the middle of a copy
        latency = 10;
        c0 = wrCount;
        sendReq(64'h2000, 64'h6000, 64'd10);
        n = 0;
        while (wrCount < c0 + 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkVal("three_writes_seen", 512'(wrCount >= c0 + 3), 512'(1));
        SoftReset = 1'b1;
        repeat (2) @(negedge clk);
        expQ.delete();
        rdQ.delete();
        SoftReset = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        checkVal("no_resp_after_reset", 512'(seen), 512'(0));
        n = 0;
        while (respQ.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkVal("late_returns_drained", 512'(respQ.size()), 512'(0));
        @(negedge clk);
        sendReq(64'h2100, 64'h6100, 64'd2);
        waitResp(64'd2, 0, lat);

        // completion back-pressure
        latency = 3;
        sendReq(64'h300, 64'h400, 64'd3);
        waitResp(64'd3, 5, lat);

        checkVal("never_read_and_write", 512'(bothErr), 512'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/avl_memcpy_srv.md
# avl_memcpy_srv

Memcpy responder on the Avalon-MM local-memory bank. Accepts one copy request (source line, destination line, line count) from the CSR-to-server initiator, reads each 512-bit line from bank 0, buffers it, writes it to the destination, then returns a completion. Sits between the server request channel and `local_mem[0]` in the application top.

## Interface
- `ADDR_W`, 27: Avalon line-address width.
- `DATA_W`, 512: line width in bits.
- `FIFO_DEPTH`, 8: line buffer depth, power of two, ≥ 4.
- `clk` in 1: clock.
- `SoftReset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_src` in 64: source line address.
- `req_dst` in 64: destination line address.
- `req_num` in 64: lines to copy.
- `resp_valid` out 1: completion present.
- `resp_ready` in 1: completion consumed.
- `resp_count` out 64: lines written (equals `req_num`).
- `avl_read`, `avl_write` out 1: Avalon commands, never both high.
- `avl_address` out `ADDR_W`: line address.
- `avl_writedata` out `DATA_W`; `avl_byteenable` out `DATA_W/8`, all ones; `avl_burstcount` out 7, constant 1.
- `avl_readdata` in `DATA_W`; `avl_readdatavalid` in 1; `avl_waitrequest` in 1.

## Operation
- States: IDLE → RUN → RESP → IDLE.
- IDLE: `req_ready`=1; on `req_valid && req_ready` latch src/dst/num, clear `rd_issued`, `wr_done`, `outstanding`; go RUN, or RESP if `req_num`==0.
- RUN read eligible: `rd_issued < num` and `outstanding + fifo_count < FIFO_DEPTH` (credit rule; FIFO can never overflow).
- RUN write eligible: FIFO non-empty.
- Arbitration when command slot free: write if eligible and (`fifo_count ≥ FIFO_DEPTH/2` or read not eligible); else read if eligible; else write if eligible.
- Once asserted, command, address and data held stable until `!avl_waitrequest`; no re-arbitration while stalled.
- Read accepted: `rd_issued++`, `outstanding++`. `avl_readdatavalid`: push `avl_readdata`, `outstanding--`. Same-cycle accept and return: `outstanding` unchanged.
- Write accepted: pop FIFO, `wr_done++`. Write address `dst + wr_done`; read address `src + rd_issued`; both truncated to `ADDR_W` bits (wraps modulo 2^ADDR_W).
- `wr_done == num` → RESP. `resp_valid` held, `resp_count` stable until `resp_ready`; then IDLE.
- `avl_readdatavalid` outside RUN: discarded, counters untouched.
- Reset mid-copy: IDLE immediately; FIFO and counters cleared; no completion issued.

## Timing
- Reset values: `req_ready`=0 during reset, 1 first cycle after; `resp_valid`=0, `resp_count`=0, `avl_read`=0, `avl_write`=0, `avl_address`=0, `avl_writedata`=0.
- First `avl_read` asserted the cycle after request acceptance.
- FIFO is first-word-fall-through: data pushed at cycle N is writable at N+1.
- `resp_valid` rises the cycle after the last write is accepted.
- Zero-wait memory with read latency L: copy of n lines completes in ≤ 2n + L + 3 cycles.

## Configuration
- `AVL_MEMCPY_PERF_EN` defined: adds output `perf_cycles` (64-bit). Clears on request acceptance, increments each RUN cycle, holds in RESP/IDLE, 0 on reset.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Shared package `avl_memcpy_pkg`: state enum `t_memcpy_state`, `t_line` (`DATA_W` vector), default widths.
- Sub-module `memcpy_line_fifo`: synchronous FWFT FIFO with push, pop, `count`, `empty` outputs, same `clk`/`SoftReset`.

## Test plan
- src=0x100, dst=0x200, num=4, zero-wait memory, latency 3 → reads 0x100–0x103, writes 0x200–0x203 carry the matching data in order; `resp_count`=4.
- num=0 → no Avalon command; `resp_valid` the cycle after acceptance, `resp_count`=0.
- num=20, `avl_waitrequest` random 50%, latency 10 → `outstanding + fifo_count` never exceeds 8; address and data stable while stalled; all 20 lines correct.
- src=0x7FFFFFE (ADDR_W=27), num=4 → reads 0x7FFFFFE, 0x7FFFFFF, 0x0, 0x1.
- `SoftReset` after 3 of 10 writes, late `avl_readdatavalid` pulses → no `resp_valid`; next request num=2 copies exactly 2 correct lines.
- `resp_ready` low for 5 cycles → `resp_valid`, `resp_count` held; `req_ready` stays 0 until handshake.
